// File: rtl/seg_pkg.sv
// Shared definitions for the sum/carry seven-segment display: glyph table,
// blank patterns, digit-slot encoding and the operand snapshot record.
package seg_pkg;

    // Digit slot index; the value doubles as the anode bit position.
    typedef enum logic [1:0] {
        DigSum = 2'd0,
        DigCo  = 2'd1,
        DigB   = 2'd2,
        DigA   = 2'd3
    } digit_e;

    // Operand/result snapshot shown for one whole frame.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] sum;
        logic       co;
    } snap_t;

    // All cathodes off (active-low).
    localparam logic [6:0] SegBlank = 7'b1111111;
    // All anodes off (active-low).
    localparam logic [3:0] AnOff    = 4'b1111;

    // Hex glyphs, active-low, bit order {g,f,e,d,c,b,a}; index 0 is the first entry.
    localparam logic [0:15][6:0] HexSegTable = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Active-low anode pattern lighting only the given digit.
    function automatic logic [3:0] digit_anode(input digit_e dig);
        return ~(4'b0001 << dig);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup of the glyph for the selected nibble.
    always_comb begin
        seg_o = HexSegTable[hex_i];
    end

endmodule

// File: rtl/sum_seg_display.sv
// Four-digit multiplexed display of an external 4-bit adder: digit 3 = a,
// digit 2 = b, digit 1 = carry-out, digit 0 = sum, dp marks carry-in on digit 0.
// Operands are sampled once per frame so a frame never mixes old and new values.
// Each digit slot starts with a short all-off window to hide ghosting.
module sum_seg_display
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic [3:0] sum,
    input  logic       co,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned     CntW   = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    digit_e          dig_q, dig_d;
    snap_t           snap_q, snap_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;

    logic            slot_wrap;
    logic            in_blank;
    logic [3:0]      nibble;
    logic [6:0]      glyph;

    // Blank window test; a zero-length window is removed entirely.
    if (BLANK_CYC == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (32'(cnt_q) < BLANK_CYC);
    end

    // Slot counter, digit index and once-per-frame snapshot next state.
    always_comb begin
        slot_wrap = (cnt_q == CntMax);
        cnt_d     = cnt_q + 1'b1;
        dig_d     = dig_q;
        snap_d    = snap_q;
        if (slot_wrap) begin
            cnt_d = '0;
            dig_d = digit_e'(dig_q + 2'd1);
            // Capture only as the last digit hands over to digit 0.
            if (dig_q == DigA) begin
                snap_d = '{a: a, b: b, ci: ci, sum: sum, co: co};
            end
        end
    end

    // Digit-select mux feeding the single shared decoder.
    always_comb begin
        nibble = 4'h0;
        unique case (dig_q)
            DigSum: nibble = snap_q.sum;
            DigCo:  nibble = {3'b000, snap_q.co};
            DigB:   nibble = snap_q.b;
            DigA:   nibble = snap_q.a;
        endcase
    end

    seg7_hex_decode u_dec (
        .hex_i (nibble),
        .seg_o (glyph)
    );

    // Output next state from the current counter state; registered for one-cycle lag.
    always_comb begin
        seg_d = SegBlank;
        dp_d  = 1'b1;
        an_d  = AnOff;
        if (!in_blank) begin
            an_d  = digit_anode(dig_q);
            seg_d = glyph;
            dp_d  = ~((dig_q == DigSum) && snap_q.ci);
        end
    end

    // State and output registers with asynchronous reset to a dark display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            dig_q  <= DigSum;
            snap_q <= '0;
            seg_q  <= SegBlank;
            dp_q   <= 1'b1;
            an_q   <= AnOff;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: doc/sum_seg_display.md
SUM_SEG_DISPLAY -- requirements
Module: sum_seg_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range 4..2^20, SHALL exceed BLANK_CYC.
REQ-002 Parameter BLANK_CYC, default 16, blanked cycles at the start of each slot; 0 disables blanking.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 a  input  4  adder operand A, same value driven into adder4.
REQ-006 b  input  4  adder operand B.
REQ-007 ci  input  1  adder carry-in.
REQ-008 sum  input  4  adder4 SUM output.
REQ-009 co  input  1  adder4 CO output.
REQ-010 seg  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 an  output  4  digit anodes, active-low, an[0] rightmost.

Function
REQ-013 Slot counter SHALL count 0..REFRESH_DIV-1 then wrap to 0, and digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-014 Snapshot register {a,b,ci,sum,co} SHALL load only on the cycle the digit index wraps 3->0; displayed values SHALL come only from the snapshot, so one frame never mixes old and new operands.
REQ-015 Digit content: digit 0 = hex(sum), digit 1 = co as '0'/'1', digit 2 = hex(b), digit 3 = hex(a).
REQ-016 dp SHALL be 0 only while digit 0 is lit and snapshot ci = 1; otherwise dp = 1.
REQ-017 Hex glyphs 0-F SHALL use standard shapes (e.g. 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-018 While slot counter < BLANK_CYC: an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-019 Outside blanking, exactly one an bit SHALL be 0, the one selected by the digit index.
REQ-020 seg, dp and an SHALL be driven directly from flops, lagging the internal counter state by exactly one cycle.
REQ-021 Input changes mid-frame SHALL have no visible effect until the next 3->0 wrap.
REQ-022 With BLANK_CYC = 0, digits SHALL switch with no all-off cycle.

Reset
REQ-023 While rst = 1: slot counter = 0, digit index = 0, snapshot = all zeros, an = 4'b1111, seg = 7'b1111111, dp = 1.
REQ-024 Reset asserted mid-slot SHALL take effect immediately and asynchronously.
REQ-025 After release, the first frame SHALL show the zero snapshot, and the first capture SHALL occur at the first 3->0 wrap.

Structure
REQ-026 Package seg_pkg SHALL hold the 16-entry hex-to-segment table, the blank pattern constant and the digit-index encoding.
REQ-027 Decoding SHALL live in one combinational sub-module, seg7_hex_decode (4-bit in, 7-bit active-low out), instantiated once and fed through a digit-select mux.
REQ-028 Counter width SHALL be derived as $clog2(REFRESH_DIV).

Verification (REFRESH_DIV = 8, BLANK_CYC = 2)
REQ-029 Reset: pulse rst mid-slot -> an = 1111, seg = 1111111 and dp = 1 in the same cycle; after release, digit 0 lights with glyph '0' after 2 blank cycles + 1 lag.
REQ-030 a=3, b=4, ci=0, sum=7, co=0 held for two frames -> in the second frame, an[3..0] slots show 3, 4, 0, 7 and dp stays 1.
REQ-031 a=F, b=1, ci=0, sum=0, co=1 -> digit 1 shows '1' (1111001) and digit 0 shows '0' (1000000).
REQ-032 a=A, b=5, ci=1, sum=0, co=1 -> dp = 0 only in digit-0 lit cycles.
REQ-033 Change a from 8 to 2 during digit 2 of a frame -> digit 3 still shows 8 that frame and shows 2 from the next frame.
REQ-034 Checker over 6 random frames: at most one an bit low per cycle, exactly 2 blank cycles per slot, and glyphs match a reference model of the snapshot.
